bp_be_stall_attribution_counters: RTL and testbench

- Synthesizable, parametrised successor to the nonsynth core profiler.
- Propagates per-stage stall-event vectors down a configurable-depth attribution pipe and priority-encodes one reason per non-committing cycle at the tail.
- Accumulates per-reason, instret and cycle counts in saturating hardware counters, readable over a 1-cycle-latency read port.
- Sits beside the BE commit path; its counters feed CSR/debug readout.

---
 rtl/bp_be_pkg.sv | 46 ++++
 rtl/bp_be_stall_attr_pipe.sv | 85 ++++++++
 rtl/bp_be_stall_attribution_counters.sv | 137 +++++++++++++
 tb/tb_bp_be_stall_attribution_counters.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_be_pkg.sv
// Shared types and counter-map helpers for the backend stall attribution counters.
package bp_be_pkg;

    localparam int bp_num_stall_reasons_gp = 24;

    // Counter map: reasons first, then instret, then cycles.
    function automatic int bp_instret_cnt_offset(input int num_reasons);
        return num_reasons;
    endfunction

    function automatic int bp_cycle_cnt_offset(input int num_reasons);
        return num_reasons + 1;
    endfunction

    localparam int bp_instret_cnt_offset_gp = bp_num_stall_reasons_gp;
    localparam int bp_cycle_cnt_offset_gp   = bp_num_stall_reasons_gp + 1;
    localparam int bp_num_stall_cnts_gp     = bp_num_stall_reasons_gp + 2;

    typedef enum logic [4:0] {
        e_stall_unknown         = 5'd0,
        e_stall_icache_miss     = 5'd1,
        e_stall_itlb_miss       = 5'd2,
        e_stall_branch_override = 5'd3,
        e_stall_ret_override    = 5'd4,
        e_stall_fe_cmd          = 5'd5,
        e_stall_fe_cmd_fence    = 5'd6,
        e_stall_mispredict      = 5'd7,
        e_stall_control_haz     = 5'd8,
        e_stall_long_haz        = 5'd9,
        e_stall_data_haz        = 5'd10,
        e_stall_aux_dep         = 5'd11,
        e_stall_load_dep        = 5'd12,
        e_stall_mul_dep         = 5'd13,
        e_stall_fma_dep         = 5'd14,
        e_stall_sb_iraw_dep     = 5'd15,
        e_stall_sb_fraw_dep     = 5'd16,
        e_stall_struct_haz      = 5'd17,
        e_stall_idiv_haz        = 5'd18,
        e_stall_fdiv_haz        = 5'd19,
        e_stall_dtlb_miss       = 5'd20,
        e_stall_dcache_miss     = 5'd21,
        e_stall_ptw_busy        = 5'd22,
        e_stall_exception       = 5'd23
    } bp_stall_reason_e;

endpackage

// File: rtl/bp_be_stall_attr_pipe.sv
// OR/shift attribution pipe, commit delay chain and tail priority encoder.
module bp_be_stall_attr_pipe
    import bp_be_pkg::*;
#(
    parameter int num_stages_p   = 8,
    parameter int num_reasons_p  = bp_num_stall_reasons_gp,
    parameter int commit_width_p = 1,
    parameter int commit_delay_p = 1,
    localparam int commit_cnt_width_lp = $clog2(commit_width_p + 1),
    localparam int reason_width_lp     = $clog2(num_reasons_p)
) (
    input  logic                                    clk_i,
    input  logic                                    reset_i,
    input  logic                                    freeze_i,
    input  logic                                    en_i,
    input  logic [num_stages_p*num_reasons_p-1:0]   stage_event_i,
    input  logic [commit_cnt_width_lp-1:0]          commit_cnt_i,
    output logic [reason_width_lp-1:0]              reason_o,
    output logic                                    stall_o,
    output logic [commit_cnt_width_lp-1:0]          commit_d_o
);

    logic [num_stages_p-1:0][num_reasons_p-1:0] stall_r;
    logic [num_stages_p-1:0][num_reasons_p-1:0] stall_n;
    logic [num_reasons_p-1:0]                   tail;
    logic [reason_width_lp-1:0]                 tail_reason;
    logic [commit_cnt_width_lp-1:0]             commit_d;

    // Each stage ORs its own events onto whatever arrived from upstream.
    for (genvar s = 0; s < num_stages_p; s++) begin : g_stage
        logic [num_reasons_p-1:0] inject;
        assign inject = stage_event_i[s*num_reasons_p +: num_reasons_p];
        if (s == 0) begin : g_head
            assign stall_n[s] = freeze_i ? '0 : inject;
        end else begin : g_body
            assign stall_n[s] = freeze_i ? '0 : (stall_r[s-1] | inject);
        end
    end

    // Attribution pipe registers.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            stall_r <= '0;
        end else begin
            stall_r <= stall_n;
        end
    end

    if (commit_delay_p == 0) begin : g_no_delay
        assign commit_d = commit_cnt_i;
    end else begin : g_delay
        logic [commit_delay_p-1:0][commit_cnt_width_lp-1:0] chain_r;

        // Commit delay chain; a freeze drops everything in flight.
        always_ff @(posedge clk_i or posedge reset_i) begin
            if (reset_i) begin
                chain_r <= '0;
            end else if (freeze_i) begin
                chain_r <= '0;
            end else begin
                chain_r[0] <= commit_cnt_i;
                for (int i = 1; i < commit_delay_p; i++) begin
                    chain_r[i] <= chain_r[i-1];
                end
            end
        end

        assign commit_d = chain_r[commit_delay_p-1];
    end

    assign tail = stall_r[num_stages_p-1];

    // Highest set index wins; an empty tail falls through to reason 0.
    always_comb begin
        tail_reason = '0;
        for (int r = 0; r < num_reasons_p; r++) begin
            tail_reason = tail[r] ? reason_width_lp'(r) : tail_reason;
        end
    end

    assign stall_o    = (commit_d == '0) & ~freeze_i & en_i;
    assign reason_o   = stall_o ? tail_reason : '0;
    assign commit_d_o = commit_d;

endmodule

// File: rtl/bp_be_stall_attribution_counters.sv
// Stall attribution counter bank with saturating counters and a 1-cycle read port.
// Optional shadow bank for atomic snapshots: define BP_STALL_ATTRIBUTION_SNAPSHOT_EN.
module bp_be_stall_attribution_counters
    import bp_be_pkg::*;
#(
    parameter int num_stages_p    = 8,
    parameter int num_reasons_p   = bp_num_stall_reasons_gp,
    parameter int counter_width_p = 32,
    parameter int commit_width_p  = 1,
    parameter int commit_delay_p  = 1,
    localparam int commit_cnt_width_lp = $clog2(commit_width_p + 1),
    localparam int reason_width_lp     = $clog2(num_reasons_p),
    localparam int addr_width_lp       = $clog2(num_reasons_p + 2)
) (
    input  logic                                    clk_i,
    input  logic                                    reset_i,
    input  logic                                    freeze_i,
    input  logic                                    en_i,
    input  logic                                    clear_i,
    input  logic [num_stages_p*num_reasons_p-1:0]   stage_event_i,
    input  logic [commit_cnt_width_lp-1:0]          commit_cnt_i,
    input  logic                                    snapshot_i,
    output logic [reason_width_lp-1:0]              reason_o,
    output logic                                    reason_v_o,
    input  logic                                    r_v_i,
    input  logic [addr_width_lp-1:0]                r_addr_i,
    output logic                                    r_v_o,
    output logic [counter_width_p-1:0]              r_data_o
);

    localparam int num_cnts_lp    = num_reasons_p + 2;
    localparam int instret_idx_lp = bp_instret_cnt_offset(num_reasons_p);
    localparam int cycle_idx_lp   = bp_cycle_cnt_offset(num_reasons_p);
    localparam logic [counter_width_p-1:0] one_lp = {{(counter_width_p-1){1'b0}}, 1'b1};

    function automatic logic [counter_width_p-1:0] sat_add(
        input logic [counter_width_p-1:0] a,
        input logic [counter_width_p-1:0] b
    );
        logic [counter_width_p:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[counter_width_p] ? {counter_width_p{1'b1}} : sum[counter_width_p-1:0];
    endfunction

    logic [reason_width_lp-1:0]                      reason;
    logic                                            stall;
    logic [commit_cnt_width_lp-1:0]                  commit_d;
    logic [num_cnts_lp-1:0][counter_width_p-1:0]     cnt_r;
    logic [num_cnts_lp-1:0][counter_width_p-1:0]     cnt_n;
    logic [num_cnts_lp-1:0][counter_width_p-1:0]     rd_bank;
    logic                                            addr_ok;

    bp_be_stall_attr_pipe #(
        .num_stages_p   (num_stages_p),
        .num_reasons_p  (num_reasons_p),
        .commit_width_p (commit_width_p),
        .commit_delay_p (commit_delay_p)
    ) pipe (
        .clk_i         (clk_i),
        .reset_i       (reset_i),
        .freeze_i      (freeze_i),
        .en_i          (en_i),
        .stage_event_i (stage_event_i),
        .commit_cnt_i  (commit_cnt_i),
        .reason_o      (reason),
        .stall_o       (stall),
        .commit_d_o    (commit_d)
    );

    assign reason_o   = reason;
    assign reason_v_o = stall;

    // Clear beats any same-cycle increment; freeze and disable both hold.
    always_comb begin
        cnt_n = cnt_r;
        if (clear_i) begin
            cnt_n = '0;
        end else if (en_i & ~freeze_i) begin
            for (int i = 0; i < num_reasons_p; i++) begin
                cnt_n[i] = sat_add(cnt_r[i],
                                   (stall && (reason == reason_width_lp'(i))) ? one_lp : '0);
            end
            cnt_n[instret_idx_lp] = sat_add(cnt_r[instret_idx_lp], counter_width_p'(commit_d));
            cnt_n[cycle_idx_lp]   = sat_add(cnt_r[cycle_idx_lp], one_lp);
        end else begin
            cnt_n = cnt_r;
        end
    end

    // Live counter bank.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_n;
        end
    end

`ifdef BP_STALL_ATTRIBUTION_SNAPSHOT_EN
    logic [num_cnts_lp-1:0][counter_width_p-1:0] shadow_r;

    // Shadow captures pre-update (and pre-clear) values; only reset zeroes it.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            shadow_r <= '0;
        end else if (snapshot_i) begin
            shadow_r <= cnt_r;
        end else begin
            shadow_r <= shadow_r;
        end
    end

    assign rd_bank = shadow_r;
`else
    logic unused_snapshot;
    assign unused_snapshot = snapshot_i;
    assign rd_bank         = cnt_r;
`endif

    assign addr_ok = ({1'b0, r_addr_i} < (addr_width_lp + 1)'(num_cnts_lp));

    // Registered read port; out-of-map addresses return zero with valid set.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_v_o    <= 1'b0;
            r_data_o <= '0;
        end else begin
            r_v_o <= r_v_i;
            if (r_v_i && addr_ok) begin
                r_data_o <= rd_bank[r_addr_i];
            end else begin
                r_data_o <= '0;
            end
        end
    end

endmodule

// File: tb/tb_bp_be_stall_attribution_counters.sv
// Self-checking bench: directed tables and sequences plus random stimulus vs a cycle-history model.
module tb_bp_be_stall_attribution_counters;

    localparam int NS   = 8;
    localparam int NR   = 24;
    localparam int CW   = 8;
    localparam int CMW  = 2;
    localparam int CD   = 1;
    localparam int NC   = NR + 2;
    localparam int MAXV = (1 << CW) - 1;
    localparam int HIST = 8192;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              freeze, en, clear, snapshot, r_v;
    logic [NS*NR-1:0]  ev;
    logic [1:0]        commit;
    logic [4:0]        r_addr;
    logic [4:0]        reason;
    logic              reason_v, r_v_out;
    logic [CW-1:0]     r_data;

    always #5 clk = ~clk;

    bp_be_stall_attribution_counters #(
        .num_stages_p(NS), .num_reasons_p(NR), .counter_width_p(CW),
        .commit_width_p(CMW), .commit_delay_p(CD)
    ) dut (
        .clk_i(clk), .reset_i(reset), .freeze_i(freeze), .en_i(en), .clear_i(clear),
        .stage_event_i(ev), .commit_cnt_i(commit), .snapshot_i(snapshot),
        .reason_o(reason), .reason_v_o(reason_v),
        .r_v_i(r_v), .r_addr_i(r_addr), .r_v_o(r_v_out), .r_data_o(r_data)
    );

    int checks = 0;
    int failures = 0;

    // Model state: input history per cycle since reset, plus counter values.
    logic [NS*NR-1:0] ev_h [HIST];
    bit               frz_h [HIST];
    int               cm_h [HIST];
    int               cyc;
    int               cnt [NC];
    int               shadow [NC];
    bit               rd_pend;
    int               rd_exp;
    int               rd_addr_q;

    typedef struct {
        logic [4:0] addr;
        int         exp;
    } rd_vec_t;
    rd_vec_t tbl[$];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int sat(input int v);
        return (v > MAXV) ? MAXV : v;
    endfunction

    // An event injected at stage k in cycle c' reaches the tail in cycle c'+NS-k unless a freeze intervened.
    function automatic int model_reason(input int c);
        logic [NR-1:0] vec;
        vec = '0;
        for (int k = 0; k < NS; k++) begin
            int src;
            bit alive;
            src = c - NS + k;
            alive = (src >= 0);
            for (int j = src; alive && j < c; j++) begin
                if (frz_h[j]) alive = 1'b0;
            end
            if (alive) vec = vec | ev_h[src][k*NR +: NR];
        end
        for (int r = NR - 1; r > 0; r--) begin
            if (vec[r]) return r;
        end
        return 0;
    endfunction

    function automatic int model_commit_d(input int c);
        int src;
        src = c - CD;
        if (src < 0) return 0;
        for (int j = src; j < c; j++) begin
            if (frz_h[j]) return 0;
        end
        return cm_h[src];
    endfunction

    task automatic idle_inputs();
        ev = '0; freeze = 1'b0; en = 1'b0; clear = 1'b0; snapshot = 1'b0;
        r_v = 1'b0; r_addr = 5'd0; commit = 2'd0;
    endtask

    // One clock with the currently driven inputs; starts and ends at a falling edge.
    task automatic step();
        int cd, rs;
        bit st;
        #1;
        if (cyc >= HIST) begin
            $display("FAIL history_bound: got %0d expected below %0d", cyc, HIST);
            $fatal(1);
        end
        ev_h[cyc] = ev; frz_h[cyc] = freeze; cm_h[cyc] = int'(commit);
        cd = model_commit_d(cyc);
        st = (cd == 0) && !freeze && en;
        rs = st ? model_reason(cyc) : 0;
        check("reason_v_o", int'(reason_v), int'(st));
        check("reason_o", int'(reason), rs);
        rd_pend = r_v;
        rd_addr_q = int'(r_addr);
        rd_exp = 0;
        if (rd_addr_q < NC) begin
`ifdef BP_STALL_ATTRIBUTION_SNAPSHOT_EN
            rd_exp = shadow[rd_addr_q];
`else
            rd_exp = cnt[rd_addr_q];
`endif
        end
        if (snapshot) shadow = cnt;
        if (clear) begin
            for (int i = 0; i < NC; i++) cnt[i] = 0;
        end else if (en && !freeze) begin
            cnt[NR+1] = sat(cnt[NR+1] + 1);
            cnt[NR]   = sat(cnt[NR] + cd);
            if (st) cnt[rs] = sat(cnt[rs] + 1);
        end
        cyc++;
        @(negedge clk);
        if (rd_pend) begin
            check("r_v_o", int'(r_v_out), 1);
            check($sformatf("r_data_o[%0d]", rd_addr_q), int'(r_data), rd_exp);
        end else begin
            check("r_v_o_idle", int'(r_v_out), 0);
        end
    endtask

    task automatic do_reset();
        idle_inputs();
        #2 reset = 1'b1;
        #1;
        check("rst_r_v_o", int'(r_v_out), 0);
        check("rst_r_data_o", int'(r_data), 0);
        check("rst_reason_v_o", int'(reason_v), 0);
        check("rst_reason_o", int'(reason), 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        cyc = 0;
        rd_pend = 1'b0;
        for (int i = 0; i < NC; i++) begin
            cnt[i] = 0;
            shadow[i] = 0;
        end
    endtask

    task automatic read_check(input string name, input int addr, input int exp);
        idle_inputs();
        r_v = 1'b1;
        r_addr = addr[4:0];
        step();
        check(name, int'(r_data), exp);
    endtask

    task automatic run_table(input string name);
        for (int i = 0; i < tbl.size(); i++) begin
            read_check($sformatf("%s_addr%0d", name, tbl[i].addr), int'(tbl[i].addr), tbl[i].exp);
        end
        tbl.delete();
    endtask

    task automatic prime(input logic [1:0] c);
        idle_inputs();
        clear = 1'b1;
        commit = c;
        step();
    endtask

    initial begin
        idle_inputs();
        do_reset();

        // Every address reads zero after reset, including the out-of-map ones.
        for (int a = 0; a < 32; a++) tbl.push_back('{addr: a[4:0], exp: 0});
        run_table("reset");

        // Single reason-5 event at stage 0 is attributed NS cycles later.
        prime(2'd1);
        for (int i = 0; i < 12; i++) begin
            idle_inputs();
            en = 1'b1;
            commit = (i == 7) ? 2'd0 : 2'd1;
            if (i == 0) ev[5] = 1'b1;
            if (i == 8) begin
                #1;
                check("single_reason", int'(reason), 5);
                check("single_reason_v", int'(reason_v), 1);
            end
            step();
        end
        tbl.push_back('{addr: 5'd5, exp: 1});
        tbl.push_back('{addr: 5'd0, exp: 0});
        tbl.push_back('{addr: 5'd3, exp: 0});
        tbl.push_back('{addr: 5'd24, exp: 11});
        tbl.push_back('{addr: 5'd25, exp: 12});
        run_table("single");

        // Reason 3 at stage 0 and reason 9 at stage 2 merge in flight; 9 wins.
        prime(2'd1);
        for (int i = 0; i < 12; i++) begin
            idle_inputs();
            en = 1'b1;
            commit = (i == 7) ? 2'd0 : 2'd1;
            if (i == 0) ev[3] = 1'b1;
            if (i == 2) ev[2*NR + 9] = 1'b1;
            if (i == 8) begin
                #1;
                check("prio_reason", int'(reason), 9);
            end
            step();
        end
        tbl.push_back('{addr: 5'd9, exp: 1});
        tbl.push_back('{addr: 5'd3, exp: 0});
        tbl.push_back('{addr: 5'd0, exp: 0});
        run_table("prio");

        // Commit two on even cycles for 100 cycles.
        prime(2'd0);
        for (int i = 0; i < 100; i++) begin
            idle_inputs();
            en = 1'b1;
            commit = (i % 2 == 0) ? 2'd2 : 2'd0;
            step();
        end
        tbl.push_back('{addr: 5'd24, exp: 100});
        tbl.push_back('{addr: 5'd0, exp: 50});
        tbl.push_back('{addr: 5'd25, exp: 100});
        tbl.push_back('{addr: 5'd1, exp: 0});
        run_table("commit");

        // Saturation: reason 1 every cycle for 270 cycles.
        prime(2'd0);
        for (int i = 0; i < 270; i++) begin
            idle_inputs();
            en = 1'b1;
            ev[1] = 1'b1;
            step();
        end
        tbl.push_back('{addr: 5'd1, exp: 255});
        tbl.push_back('{addr: 5'd0, exp: 8});
        tbl.push_back('{addr: 5'd25, exp: 255});
        tbl.push_back('{addr: 5'd24, exp: 0});
        run_table("sat");
        // Clear with a live stall event; the coincident read sees pre-clear data.
        idle_inputs();
        en = 1'b1; ev[1] = 1'b1; clear = 1'b1; r_v = 1'b1; r_addr = 5'd1;
        step();
        check("read_during_clear", int'(r_data), 255);
        tbl.push_back('{addr: 5'd1, exp: 0});
        tbl.push_back('{addr: 5'd25, exp: 0});
        tbl.push_back('{addr: 5'd0, exp: 0});
        run_table("clear");

        // instret partial add clamps: 254 + 2 saturates at 255.
        prime(2'd2);
        for (int i = 0; i < 127; i++) begin
            idle_inputs();
            en = 1'b1;
            commit = 2'd2;
            step();
        end
        read_check("instret_254", 24, 254);
        idle_inputs(); commit = 2'd2; step();
        idle_inputs(); en = 1'b1; commit = 2'd2; step();
        read_check("instret_clamp", 24, 255);
        read_check("cycles_128", 25, 128);

        // Snapshot holds 7 while live reason-2 count moves on to 10.
        idle_inputs();
        clear = 1'b1; ev[7*NR + 2] = 1'b1;
        step();
        for (int i = 0; i < 7; i++) begin
            idle_inputs();
            en = 1'b1;
            if (i < 6) ev[7*NR + 2] = 1'b1;
            step();
        end
        idle_inputs();
        snapshot = 1'b1; ev[7*NR + 2] = 1'b1;
        step();
        for (int i = 0; i < 3; i++) begin
            idle_inputs();
            en = 1'b1;
            if (i < 2) ev[7*NR + 2] = 1'b1;
            step();
        end
`ifdef BP_STALL_ATTRIBUTION_SNAPSHOT_EN
        read_check("snapshot_reason2", 2, 7);
`else
        read_check("snapshot_reason2", 2, 10);
`endif

        // Randomized traffic with a mid-count reset in between.
        for (int phase = 0; phase < 2; phase++) begin
            for (int n = 0; n < 700; n++) begin
                ev = '0;
                for (int s = 0; s < NS; s++) begin
                    if ($urandom_range(3) == 0) ev[s*NR + int'($urandom_range(NR - 1))] = 1'b1;
                end
                freeze   = ($urandom_range(15) == 0);
                en       = ($urandom_range(7) != 0);
                clear    = ($urandom_range(63) == 0);
                snapshot = ($urandom_range(31) == 0);
                commit   = ($urandom_range(1) == 0) ? 2'd0 : 2'($urandom_range(2));
                r_v      = ($urandom_range(1) == 1);
                r_addr   = 5'($urandom_range(31));
                step();
            end
            if (phase == 0) begin
                do_reset();
                for (int a = 0; a < NC; a++) tbl.push_back('{addr: a[4:0], exp: 0});
                run_table("midreset");
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
